pcm_stream_reader: RTL and testbench

- Playback-side counterpart of the ioctl→DDRAM wave loader.
- Streams little-endian signed 16-bit PCM samples from byte-wide DDRAM through the ddram bridge rd/ready interface.
- Paces output at a fixed sample rate derived from the system clock.
- Drives the audio mixer input (pcm_audio) in the emu top level.

---
 rtl/pcm_stream_reader_if.sv | 25 ++
 rtl/pcm_stream_reader.sv | 245 ++++++++++++++++++++++++
 tb/tb_pcm_stream_reader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_stream_reader_if.sv
// Byte-wide read port between the PCM reader and the DDRAM bridge.
interface pcm_stream_reader_if #(
  parameter int unsigned ADDR_W = 28
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              mem_ready;

  // Reader side issues addresses and read pulses.
  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data,
    input  mem_ready
  );

  // Bridge side returns data with a one-cycle ready pulse.
  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data,
    output mem_ready
  );
endinterface

// File: rtl/pcm_stream_reader.sv
// Streams little-endian signed 16-bit PCM from byte-wide DDRAM at a fixed
// sample rate, one prefetched sample ahead of the output.
module pcm_stream_reader #(
  parameter int unsigned CLK_HZ    = 24000000,
  parameter int unsigned SAMPLE_HZ = 22050,
  parameter int unsigned ADDR_W    = 28
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                loop,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  pcm_stream_reader_if.master mem,
  output logic [15:0]         pcm,
  output logic                pcm_strobe,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  localparam int unsigned ACC_W = 32;
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_LO = 3'd1,
    WAIT_LO  = 3'd2,
    FETCH_HI = 3'd3,
    WAIT_HI  = 3'd4,
    FULL     = 3'd5,
    DRAIN    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   nsamp_q, nsamp_d;
  logic [ADDR_W-1:0]   remain_q, remain_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          lo_q, lo_d;
  logic [15:0]         pend_q, pend_d;
  logic [15:0]         pcm_q, pcm_d;
  logic                rd_q, rd_d;
  logic                strobe_q, strobe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                under_q, under_d;
  logic                stale_q, stale_d;

  logic [SUM_W-1:0]    acc_sum_c;
  logic                run_c;
  logic                tick_c;
  logic                waiting_c;
  logic                fetching_c;

  // Phase accumulator step and sample tick.
  always_comb begin
    run_c      = (state_q != IDLE) && !pause;
    acc_sum_c  = SUM_W'(acc_q) + SUM_W'(SAMPLE_HZ);
    tick_c     = run_c && (acc_sum_c >= SUM_W'(CLK_HZ));
    waiting_c  = (state_q == WAIT_LO) || (state_q == WAIT_HI);
    fetching_c = (state_q == FETCH_LO) || (state_q == FETCH_HI) || waiting_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    rd_ptr_d = rd_ptr_q;
    nsamp_d  = nsamp_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    lo_d     = lo_q;
    pend_d   = pend_q;
    pcm_d    = pcm_q;
    rd_d     = 1'b0;
    strobe_d = 1'b0;
    done_d   = done_q;
    under_d  = under_q;
    stale_d  = stale_q;
    busy_d   = busy_q;

    if (run_c) begin
      acc_d = tick_c ? ACC_W'(acc_sum_c - SUM_W'(CLK_HZ)) : ACC_W'(acc_sum_c);
    end

    // A ready that belongs to an abandoned read is consumed here.
    if (stale_q && mem.mem_ready) begin
      stale_d = 1'b0;
    end

    // Tick while the next sample is still being fetched: starved.
    if (tick_c && fetching_c) begin
      under_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
      end
      FETCH_LO: begin
        // Hold off while an abandoned read is still in flight.
        if (!pause && !stale_q) begin
          rd_d    = 1'b1;
          addr_d  = rd_ptr_q;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (mem.mem_ready) begin
          lo_d    = mem.mem_data;
          state_d = FETCH_HI;
        end
      end
      FETCH_HI: begin
        if (!pause) begin
          rd_d    = 1'b1;
          addr_d  = rd_ptr_q + ADDR_W'(1);
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (mem.mem_ready) begin
          pend_d   = {mem.mem_data, lo_q};
          rd_ptr_d = rd_ptr_q + ADDR_W'(2);
          remain_d = remain_q - ADDR_W'(1);
          state_d  = FULL;
        end
      end
      FULL: begin
        if (tick_c) begin
          pcm_d    = pend_q;
          strobe_d = 1'b1;
          if (remain_q != '0) begin
            state_d = FETCH_LO;
          end else if (loop) begin
            rd_ptr_d = base_q;
            remain_d = nsamp_q;
            state_d  = FETCH_LO;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (tick_c) begin
          pcm_d    = '0;
          strobe_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Leaving with a read outstanding: remember to drop its ready.
    if ((start || stop) && waiting_c && !mem.mem_ready) begin
      stale_d = 1'b1;
    end

    // Start (re)latches the buffer; stop wins when both are asserted.
    if (start && !stop) begin
      base_d   = base_addr;
      rd_ptr_d = base_addr;
      nsamp_d  = length >> 1;
      remain_d = length >> 1;
      acc_d    = '0;
      rd_d     = 1'b0;
      strobe_d = 1'b0;
      under_d  = 1'b0;
      if (length < ADDR_W'(2)) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        done_d  = 1'b0;
        state_d = FETCH_LO;
      end
    end

    // Abort: silence output, keep sticky status.
    if (stop) begin
      state_d  = IDLE;
      acc_d    = '0;
      pcm_d    = '0;
      rd_d     = 1'b0;
      strobe_d = 1'b0;
      done_d   = done_q;
      under_d  = under_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      rd_ptr_q <= '0;
      nsamp_q  <= '0;
      remain_q <= '0;
      addr_q   <= '0;
      lo_q     <= '0;
      pend_q   <= '0;
      pcm_q    <= '0;
      rd_q     <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      under_q  <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      rd_ptr_q <= rd_ptr_d;
      nsamp_q  <= nsamp_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
      lo_q     <= lo_d;
      pend_q   <= pend_d;
      pcm_q    <= pcm_d;
      rd_q     <= rd_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      under_q  <= under_d;
      stale_q  <= stale_d;
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_rd   = rd_q;
  assign pcm          = pcm_q;
  assign pcm_strobe   = strobe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign underrun     = under_q;

endmodule

// File: tb/tb_pcm_stream_reader.sv
// Directed bench for pcm_stream_reader with a latency-configurable byte memory.
module tb_pcm_stream_reader;

  localparam int unsigned ADDR_W = 28;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, stop, pause, loop;
  logic [ADDR_W-1:0] base_addr, length;
  logic [15:0]       pcm;
  logic              pcm_strobe, busy, done, underrun;

  pcm_stream_reader_if #(.ADDR_W(ADDR_W)) mif ();

  pcm_stream_reader #(
    .CLK_HZ   (1000),
    .SAMPLE_HZ(100),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop      (loop),
    .base_addr (base_addr),
    .length    (length),
    .mem       (mif),
    .pcm       (pcm),
    .pcm_strobe(pcm_strobe),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  logic [7:0]        mem [0:1023];
  int                lat = 2;
  int                resp_cnt = 0;
  logic [ADDR_W-1:0] resp_addr = '0;
  int                addr_unstable = 0;

  logic [17:0]       sq[$];      // {busy, done, pcm} at each strobe
  int                st[$];      // cycle of each strobe
  logic [ADDR_W-1:0] rd_log[$];
  int                cyc_n = 0;
  int                rd_double = 0;
  int                held_viol = 0;
  logic              rd_prev = 1'b0;
  logic [15:0]       last_pcm = '0;

  int vectors = 0;
  int miscompares = 0;
  int s0, r0, h0, u0, d0;

  // Memory model: answers each read after lat falling edges.
  always @(negedge clk) begin
    mif.mem_ready = 1'b0;
    if (resp_cnt > 0) begin
      if (mif.mem_addr !== resp_addr) addr_unstable++;
      resp_cnt--;
      if (resp_cnt == 0) begin
        mif.mem_ready = 1'b1;
        mif.mem_data  = mem[resp_addr[9:0]];
      end
    end
    if (mif.mem_rd === 1'b1) begin
      resp_addr = mif.mem_addr;
      resp_cnt  = lat;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    cyc_n++;
    if (pcm_strobe === 1'b1) begin
      sq.push_back({busy, done, pcm});
      st.push_back(cyc_n);
    end
    if (mif.mem_rd === 1'b1) begin
      rd_log.push_back(mif.mem_addr);
      if (rd_prev) rd_double++;
    end
    rd_prev = mif.mem_rd;
    if (pcm_strobe !== 1'b1 && pcm !== last_pcm) held_viol++;
    last_pcm = pcm;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic mark();
    s0 = sq.size();
    r0 = rd_log.size();
    h0 = held_viol;
    u0 = addr_unstable;
    d0 = rd_double;
  endtask

  function automatic int nstrobes();
    return sq.size() - s0;
  endfunction

  function automatic int nreads();
    return rd_log.size() - r0;
  endfunction

  task automatic chk_strobe(input string tag, input int i, input logic [17:0] exp);
    logic [31:0] obs;
    obs = 32'hDEAD_BEEF;
    if (s0 + i < sq.size()) obs = 32'(sq[s0 + i]);
    check(tag, obs, 32'(exp));
  endtask

  task automatic chk_rd(input string tag, input int i, input logic [ADDR_W-1:0] exp);
    logic [31:0] obs;
    obs = 32'hDEAD_BEEF;
    if (r0 + i < rd_log.size()) obs = 32'(rd_log[r0 + i]);
    check(tag, obs, 32'(exp));
  endtask

  task automatic kick(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (nstrobes() < n && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 32'(nstrobes() >= n), 32'd1);
  endtask

  task automatic wait_rd(input logic [ADDR_W-1:0] a, input int budget, input string tag);
    int k;
    k = 0;
    while (!(mif.mem_rd === 1'b1 && mif.mem_addr == a) && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 32'(mif.mem_rd === 1'b1 && mif.mem_addr == a), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
    base_addr = '0; length = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    mem[10'h100] = 8'h34; mem[10'h101] = 8'h12; mem[10'h102] = 8'hCD;
    mem[10'h103] = 8'hAB; mem[10'h104] = 8'h00; mem[10'h105] = 8'h80;
    mem[10'h300] = 8'h01; mem[10'h301] = 8'h00; mem[10'h302] = 8'h02; mem[10'h303] = 8'h00;
    mem[10'h400] = 8'h11; mem[10'h401] = 8'h11; mem[10'h402] = 8'h22;
    mem[10'h403] = 8'h22; mem[10'h404] = 8'h33; mem[10'h405] = 8'h33;

    // Reset values.
    cyc();
    check("rst_pcm",      32'(pcm),          32'd0);
    check("rst_strobe",   32'(pcm_strobe),   32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_done",     32'(done),         32'd0);
    check("rst_underrun", 32'(underrun),     32'd0);
    check("rst_mem_rd",   32'(mif.mem_rd),   32'd0);
    check("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Basic playback.
    lat = 2;
    mark();
    kick(28'h100, 28'd6);
    check("basic_busy", 32'(busy), 32'd1);
    wait_idle(200, "basic_timeout");
    check("basic_nstrobe", 32'(nstrobes()), 32'd4);
    chk_strobe("basic_s0", 0, 18'h21234);
    chk_strobe("basic_s1", 1, 18'h2ABCD);
    chk_strobe("basic_s2", 2, 18'h28000);
    chk_strobe("basic_s3", 3, 18'h10000);
    check("basic_nreads", 32'(nreads()), 32'd6);
    for (int i = 0; i < 6; i++) chk_rd($sformatf("basic_addr%0d", i), i, 28'h100 + ADDR_W'(i));
    check("basic_rd_single", 32'(rd_double - d0), 32'd0);
    check("basic_addr_stable", 32'(addr_unstable - u0), 32'd0);
    check("basic_underrun", 32'(underrun), 32'd0);
    check("basic_done", 32'(done), 32'd1);

    // Rate: one strobe every 10 cycles.
    mark();
    kick(28'h200, 28'd44);
    wait_strobes(21, 400, "rate_timeout");
    if (nstrobes() >= 21) begin
      for (int i = 1; i <= 20; i++)
        check($sformatf("rate_gap%0d", i), 32'(st[s0 + i] - st[s0 + i - 1]), 32'd10);
    end
    for (int i = 0; i < 20; i++)
      chk_strobe($sformatf("rate_val%0d", i), i, {2'b10, 8'(2 * i + 1), 8'(2 * i)});
    check("rate_underrun", 32'(underrun), 32'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("rate_stop_busy", 32'(busy), 32'd0);
    cyc();

    // Loop, then release loop.
    mark();
    loop = 1'b1;
    kick(28'h300, 28'd4);
    wait_strobes(5, 200, "loop_timeout");
    loop = 1'b0;
    wait_idle(200, "loop_end_timeout");
    check("loop_nstrobe", 32'(nstrobes()), 32'd7);
    chk_strobe("loop_s0", 0, 18'h20001);
    chk_strobe("loop_s1", 1, 18'h20002);
    chk_strobe("loop_s2", 2, 18'h20001);
    chk_strobe("loop_s3", 3, 18'h20002);
    chk_strobe("loop_s4", 4, 18'h20001);
    chk_strobe("loop_s5", 5, 18'h20002);
    chk_strobe("loop_s6", 6, 18'h10000);

    // Underrun with slow memory.
    lat = 40;
    mark();
    kick(28'h400, 28'd6);
    wait_idle(1500, "under_timeout");
    check("under_flag", 32'(underrun), 32'd1);
    check("under_nstrobe", 32'(nstrobes()), 32'd4);
    chk_strobe("under_s0", 0, 18'h21111);
    chk_strobe("under_s1", 1, 18'h22222);
    chk_strobe("under_s2", 2, 18'h23333);
    chk_strobe("under_s3", 3, 18'h10000);
    check("under_pcm_held", 32'(held_viol - h0), 32'd0);
    check("under_addr_stable", 32'(addr_unstable - u0), 32'd0);

    // Length 1: immediate done, no reads.
    lat = 2;
    mark();
    kick(28'h500, 28'd1);
    check("len1_done", 32'(done), 32'd1);
    check("len1_busy", 32'(busy), 32'd0);
    check("len1_underrun_clr", 32'(underrun), 32'd0);
    repeat (5) cyc();
    check("len1_nreads", 32'(nreads()), 32'd0);

    // Length 5: trailing byte never read.
    mark();
    kick(28'h100, 28'd5);
    check("len5_done_clr", 32'(done), 32'd0);
    wait_idle(200, "len5_timeout");
    check("len5_nreads", 32'(nreads()), 32'd4);
    chk_strobe("len5_s0", 0, 18'h21234);
    chk_strobe("len5_s1", 1, 18'h2ABCD);
    chk_strobe("len5_s2", 2, 18'h10000);

    // Stop while the second sample's high byte is in flight.
    lat = 4;
    mark();
    kick(28'h100, 28'd6);
    wait_rd(28'h103, 100, "stop_wait_hi");
    check("stop_pcm_before", 32'(pcm), 32'h1234);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_pcm", 32'(pcm), 32'd0);
    check("stop_done_kept", 32'(done), 32'd0);
    s0 = sq.size();
    repeat (15) cyc();
    check("stop_late_ready", 32'(nstrobes()), 32'd0);
    check("stop_still_idle", 32'(busy), 32'd0);

    // Stop beats a simultaneous start.
    mark();
    stop = 1'b1;
    kick(28'h100, 28'd6);
    stop = 1'b0;
    check("stop_prio_busy", 32'(busy), 32'd0);
    repeat (5) cyc();
    check("stop_prio_nreads", 32'(nreads()), 32'd0);

    // Asynchronous reset in the middle of a read.
    mark();
    kick(28'h100, 28'd6);
    wait_rd(28'h101, 100, "rst_wait_hi");
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_mem_rd",   32'(mif.mem_rd),   32'd0);
    check("arst_mem_addr", 32'(mif.mem_addr), 32'd0);
    check("arst_busy",     32'(busy),         32'd0);
    check("arst_pcm",      32'(pcm),          32'd0);
    check("arst_done",     32'(done),         32'd0);
    check("arst_underrun", 32'(underrun),     32'd0);
    repeat (3) cyc();
    reset_n = 1'b1;
    s0 = sq.size();
    repeat (20) cyc();
    check("arst_no_strobe", 32'(nstrobes()), 32'd0);
    check("arst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
